cipher_pipe_param: RTL and testbench

- Parametrised successor to the fixed 5-round payload decryption pipeline in the HW_Acc datapath.
- Sits between the packet input FIFO and the output queue, on the 64-bit data / 8-bit ctrl stream.
- Adds the following over the fixed pipeline:
  - configurable round count and lane width;
  - per-beat encrypt/decrypt mode;
  - true backpressure, where the pipeline stalls instead of dropping beats;
  - a busy flag and a processed-beat counter.
- Non-payload beats (headers) pass through with identical latency, unmodified.

---
 rtl/cipher_pipe_pkg.sv | 65 ++++++
 rtl/cipher_round_stage.sv | 80 ++++++++
 rtl/cipher_pipe_param.sv | 88 ++++++++
 tb/tb_cipher_pipe_param.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pipe_pkg.sv
// Shared types, mode encodings and lane-width generic round functions for the
// payload cipher pipeline; usable by both the RTL and a reference model.
package cipher_pipe_pkg;

    localparam int unsigned LW_DEFAULT = 16;
    localparam int unsigned LW_MAX     = 32;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    typedef logic [LW_MAX-1:0]      lane_t;
    typedef logic [3:0][LW_MAX-1:0] quad_t;

    function automatic lane_t lane_mask(input int unsigned lw);
        return (lw >= LW_MAX) ? '1 : ((lane_t'(1) << lw) - lane_t'(1));
    endfunction

    // Rotates assume x already holds only the low lw bits.
    function automatic lane_t rotl1(input lane_t x, input int unsigned lw);
        return ((x << 1) | (x >> (lw - 1))) & lane_mask(lw);
    endfunction

    function automatic lane_t rotr1(input lane_t x, input int unsigned lw);
        return ((x >> 1) | (x << (lw - 1))) & lane_mask(lw);
    endfunction

    function automatic quad_t enc_round(input quad_t d, input lane_t k, input int unsigned lw);
        lane_t m;
        lane_t e0;
        lane_t e1;
        lane_t e2;
        lane_t e3;
        quad_t o;
        m  = lane_mask(lw);
        e0 = (d[0] ^ k) & m;
        e1 = (d[1] + e0) & m;
        e2 = (rotl1(d[2] & m, lw) ^ e1) & m;
        e3 = (d[3] - k) & m;
        o[0] = e1;
        o[1] = e0;
        o[2] = e3;
        o[3] = e2;
        return o;
    endfunction

    function automatic quad_t dec_round(input quad_t o, input lane_t k, input int unsigned lw);
        lane_t m;
        lane_t e0;
        lane_t e1;
        lane_t e2;
        lane_t e3;
        quad_t d;
        m  = lane_mask(lw);
        e1 = o[0] & m;
        e0 = o[1] & m;
        e3 = o[2] & m;
        e2 = o[3] & m;
        d[0] = (e0 ^ k) & m;
        d[1] = (e1 - e0) & m;
        d[2] = rotr1((e2 ^ e1) & m, lw);
        d[3] = (e3 + k) & m;
        return d;
    endfunction

endpackage

// File: rtl/cipher_round_stage.sv
// One registered pipeline stage: applies the mode-selected round to payload beats and
// carries ctrl, payload, mode and valid alongside the data.
module cipher_round_stage
    import cipher_pipe_pkg::*;
#(
    parameter int unsigned LW     = LW_DEFAULT,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic [4*LW-1:0]   i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_payload,
    input  logic              i_mode,
    input  logic              i_valid,
    input  logic [LW-1:0]     i_key_enc,
    input  logic [LW-1:0]     i_key_dec,
    output logic [4*LW-1:0]   o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_payload,
    output logic              o_mode,
    output logic              o_valid
);

    quad_t             w_in;
    quad_t             w_rnd;
    logic [4*LW-1:0]   w_res;
    logic              w_unused_rnd;

    logic [4*LW-1:0]   r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_payload;
    logic              r_mode;
    logic              r_valid;

    always_comb begin
        w_in = '0;
        for (int j = 0; j < 4; j++) begin
            w_in[j] = lane_t'(i_data[j*LW +: LW]);
        end
        if (i_mode == MODE_ENC) begin
            w_rnd = enc_round(w_in, lane_t'(i_key_enc), LW);
        end else begin
            w_rnd = dec_round(w_in, lane_t'(i_key_dec), LW);
        end
        // Headers bypass the round untouched.
        w_res = i_data;
        if (i_payload) begin
            for (int j = 0; j < 4; j++) begin
                w_res[j*LW +: LW] = w_rnd[j][LW-1:0];
            end
        end
        // Round results are masked to LW bits; the upper lane bits are always zero.
        w_unused_rnd = ^w_rnd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_ctrl    <= '0;
            r_payload <= 1'b0;
            r_mode    <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_en) begin
            r_data    <= w_res;
            r_ctrl    <= i_ctrl;
            r_payload <= i_payload;
            r_mode    <= i_mode;
            r_valid   <= i_valid;
        end
    end

    assign o_data    = r_data;
    assign o_ctrl    = r_ctrl;
    assign o_payload = r_payload;
    assign o_mode    = r_mode;
    assign o_valid   = r_valid;

endmodule

// File: rtl/cipher_pipe_param.sv
// Parametrised payload encrypt/decrypt pipeline with stall-based backpressure,
// header bypass, busy flag and saturating delivered-payload counter.
module cipher_pipe_param
    import cipher_pipe_pkg::*;
#(
    parameter int unsigned N_STAGES = 5,
    parameter int unsigned LW       = LW_DEFAULT,
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4*LW-1:0]        in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic                   in_wr,
    output logic                   in_rdy,
    input  logic                   in_payload,
    input  logic                   in_mode,
    input  logic [N_STAGES*LW-1:0] key,
    output logic [4*LW-1:0]        out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic                   out_wr,
    input  logic                   out_rdy,
    output logic                   busy,
    output logic [CNT_W-1:0]       beat_cnt
);

    // Index 0 is the pipeline input; index i+1 is the output of stage i.
    logic [N_STAGES:0][4*LW-1:0]   w_data;
    logic [N_STAGES:0][CTRL_W-1:0] w_ctrl;
    logic [N_STAGES:0]             w_payload;
    logic [N_STAGES:0]             w_mode;
    logic [N_STAGES:0]             w_valid;
    logic                          w_en;
    logic                          w_unused_mode;

    logic [CNT_W-1:0]              r_cnt;

    assign w_data[0]    = in_data;
    assign w_ctrl[0]    = in_ctrl;
    assign w_payload[0] = in_payload;
    assign w_mode[0]    = in_mode;
    assign w_valid[0]   = in_wr;

    // Whole pipe advances together; it only freezes when the last beat is refused.
    assign w_en   = out_rdy | ~w_valid[N_STAGES];
    assign in_rdy = w_en;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        cipher_round_stage #(
            .LW     (LW),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_en      (w_en),
            .i_data    (w_data[i]),
            .i_ctrl    (w_ctrl[i]),
            .i_payload (w_payload[i]),
            .i_mode    (w_mode[i]),
            .i_valid   (w_valid[i]),
            .i_key_enc (key[i*LW +: LW]),
            .i_key_dec (key[(N_STAGES-1-i)*LW +: LW]),
            .o_data    (w_data[i+1]),
            .o_ctrl    (w_ctrl[i+1]),
            .o_payload (w_payload[i+1]),
            .o_mode    (w_mode[i+1]),
            .o_valid   (w_valid[i+1])
        );
    end

    assign out_data      = w_data[N_STAGES];
    assign out_ctrl      = w_ctrl[N_STAGES];
    assign out_wr        = w_valid[N_STAGES];
    assign busy          = |w_valid[N_STAGES:1];
    assign w_unused_mode = w_mode[N_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (out_wr && out_rdy && w_payload[N_STAGES] && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_cipher_pipe_param.sv
// Bench for cipher_pipe_param: transaction-level reference model with a per-cycle
// compare process, plus directed vectors on a default and a 1-stage/4-bit-counter instance.
module tb_cipher_pipe_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic        in_payload;
    logic        in_mode;
    logic [79:0] key;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        busy;
    logic [31:0] beat_cnt;

    logic [63:0] s_in_data;
    logic [7:0]  s_in_ctrl;
    logic        s_in_wr;
    logic        s_in_rdy;
    logic        s_in_payload;
    logic        s_in_mode;
    logic [15:0] s_key;
    logic [63:0] s_out_data;
    logic [7:0]  s_out_ctrl;
    logic        s_out_wr;
    logic        s_out_rdy;
    logic        s_busy;
    logic [3:0]  s_beat_cnt;

    always #5 clk = ~clk;

    cipher_pipe_param #(.N_STAGES(5), .LW(16), .CTRL_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy), .in_payload(in_payload), .in_mode(in_mode), .key(key),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    cipher_pipe_param #(.N_STAGES(1), .LW(16), .CTRL_W(8), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
        .in_wr(s_in_wr), .in_rdy(s_in_rdy), .in_payload(s_in_payload), .in_mode(s_in_mode),
        .key(s_key), .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_wr(s_out_wr),
        .out_rdy(s_out_rdy), .busy(s_busy), .beat_cnt(s_beat_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference rounds written directly on 16-bit lanes; word = {lane3, lane2, lane1, lane0}.
    function automatic logic [63:0] m_enc(input logic [63:0] x, input logic [15:0] k);
        logic [15:0] d0, d1, d2, d3, e0, e1, e2, e3;
        {d3, d2, d1, d0} = x;
        e0 = d0 ^ k;
        e1 = d1 + e0;
        e2 = {d2[14:0], d2[15]} ^ e1;
        e3 = d3 - k;
        return {e2, e3, e0, e1};
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] x, input logic [15:0] k);
        logic [15:0] o0, o1, o2, o3, t, d0, d1, d2, d3;
        {o3, o2, o1, o0} = x;
        d0 = o1 ^ k;
        d1 = o0 - o1;
        t  = o3 ^ o0;
        d2 = {t[0], t[15:1]};
        d3 = o2 + k;
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [63:0] m_pipe(input logic [63:0] x, input logic p, input logic m,
                                           input logic [79:0] k);
        logic [63:0] y;
        y = x;
        if (p) begin
            for (int i = 0; i < 5; i++) begin
                if (m) y = m_enc(y, k[i*16 +: 16]);
                else   y = m_dec(y, k[(4-i)*16 +: 16]);
            end
        end
        return y;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        payload;
    } exp_t;

    exp_t        q_exp[$];
    logic [63:0] cap[$];
    int unsigned m_cnt = 0;
    int          m_stalls = 0;
    logic        held_v = 1'b0;
    logic [63:0] held_data;
    logic [7:0]  held_ctrl;

    // Compare process: evaluates the transfer that the next rising edge will perform.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q_exp.delete();
            m_cnt  = 0;
            held_v = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(q_exp.size() != 0));
            chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            if (held_v) begin
                chk("stall_hold_wr", 64'(out_wr), 64'd1);
                chk("stall_hold_data", out_data, held_data);
                chk("stall_hold_ctrl", 64'(out_ctrl), 64'(held_ctrl));
            end
            if (out_wr && !out_rdy) begin
                chk("stall_in_rdy", 64'(in_rdy), 64'd0);
                m_stalls++;
                held_v    = 1'b1;
                held_data = out_data;
                held_ctrl = out_ctrl;
            end else begin
                held_v = 1'b0;
            end
            if (out_wr && out_rdy) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", out_data);
                end else begin
                    e = q_exp.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    if (e.payload && m_cnt != 32'hFFFF_FFFF) m_cnt++;
                end
                cap.push_back(out_data);
            end
            if (in_wr && in_rdy) begin
                e.data    = m_pipe(in_data, in_payload, in_mode, key);
                e.ctrl    = in_ctrl;
                e.payload = in_payload;
                q_exp.push_back(e);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] c, input logic p, input logic m);
        in_data    = d;
        in_ctrl    = c;
        in_payload = p;
        in_mode    = m;
        in_wr      = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_rdy) begin
                @(posedge clk);
                #1;
                in_wr = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_rdy=0 for 200 cycles, expected acceptance");
        in_wr = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (!busy && q_exp.size() == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got busy=%0d pending=%0d, expected empty", busy,
                 q_exp.size());
    endtask

    task automatic s_vec(input string name, input logic [63:0] d, input logic m,
                         input logic [63:0] exp);
        s_in_data    = d;
        s_in_mode    = m;
        s_in_payload = 1'b1;
        s_in_ctrl    = 8'hA5;
        s_in_wr      = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(s_in_rdy), 64'd1);
        @(posedge clk);
        #1;
        s_in_wr = 1'b0;
        chk({name, "_wr"}, 64'(s_out_wr), 64'd1);
        chk({name, "_data"}, s_out_data, exp);
        chk({name, "_ctrl"}, 64'(s_out_ctrl), 64'hA5);
        chk({name, "_busy"}, 64'(s_busy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] orig[100];
    logic [63:0] ct[100];

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        in_data = '0; in_ctrl = '0; in_wr = 1'b0; in_payload = 1'b0; in_mode = 1'b0;
        key = '0; out_rdy = 1'b1;
        s_in_data = '0; s_in_ctrl = '0; s_in_wr = 1'b0; s_in_payload = 1'b0;
        s_in_mode = 1'b0; s_key = '0; s_out_rdy = 1'b1;

        // Model pins, hand-computed.
        chk("model_enc_k0", m_enc(64'h0001_0002_0003_0004, 16'h0000), 64'h0003_0001_0004_0007);
        chk("model_enc_k1", m_enc(64'h0001_0002_0003_0004, 16'h0001), 64'h000C_0000_0005_0008);
        chk("model_rotl_wrap", m_enc(64'h0000_8000_0000_0000, 16'h0000),
            64'h0001_0000_0000_0000);
        chk("model_dec_k0", m_dec(64'h0003_0001_0004_0007, 16'h0000), 64'h0001_0002_0003_0004);

        #1 reset_n = 1'b0;
        #2;
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Header bypass and latency.
        key = 80'h1111_2222_3333_4444_5555;
        send(64'hDEADBEEF_01234567, 8'hFF, 1'b0, 1'b1);
        lat = 1;
        while (!out_wr && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hdr_latency", 64'(lat), 64'd5);
        chk("hdr_data", out_data, 64'hDEADBEEF_01234567);
        chk("hdr_ctrl", 64'(out_ctrl), 64'hFF);
        drain();
        chk("hdr_no_count", 64'(beat_cnt), 64'd0);

        // Encrypt 100 beats, then decrypt the ciphertext back.
        cap.delete();
        for (int i = 0; i < 100; i++) begin
            orig[i] = {$urandom(), $urandom()};
            send(orig[i], 8'(i), 1'b1, 1'b1);
        end
        drain();
        chk("rt_enc_count", 64'(cap.size()), 64'd100);
        for (int i = 0; i < 100; i++) ct[i] = (i < cap.size()) ? cap[i] : 64'd0;
        cap.delete();
        for (int i = 0; i < 100; i++) send(ct[i], 8'(i), 1'b1, 1'b0);
        drain();
        chk("rt_dec_count", 64'(cap.size()), 64'd100);
        if (cap.size() == 100) begin
            for (int i = 0; i < 100; i++) chk($sformatf("rt_recover[%0d]", i), cap[i], orig[i]);
        end
        chk("rt_beat_cnt", 64'(beat_cnt), 64'd200);

        // Payload latency in decrypt mode.
        send(64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1, 1'b0);
        lat = 1;
        while (!out_wr && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("pay_latency", 64'(lat), 64'd5);
        drain();
        chk("pay_beat_cnt", 64'(beat_cnt), 64'd201);

        // Backpressure: out_rdy low for cycles 7..12 of a 20-beat mixed stream.
        key = 80'h0123_4567_89AB_CDEF_F00D;
        cap.delete();
        m_stalls = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send({$urandom(), $urandom()}, 8'(i + 64), (i % 3) != 0, (i % 2) == 0);
                end
            end
            begin
                for (int c = 1; c <= 20; c++) begin
                    @(posedge clk);
                    #1;
                    out_rdy = !(c >= 7 && c <= 12);
                end
            end
        join
        out_rdy = 1'b1;
        drain();
        chk("bp_count", 64'(cap.size()), 64'd20);
        chk("bp_stall_cycles", 64'(m_stalls), 64'd6);

        // Asynchronous reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(64'hA5A5_0000_0000_0000 + 64'(i), 8'(i), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_out_wr", 64'(out_wr), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_wr", 64'(out_wr), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        send(64'h1111_2222_3333_4444, 8'h01, 1'b1, 1'b1);
        send(64'h5555_6666_7777_8888, 8'h02, 1'b0, 1'b0);
        send(64'h9999_AAAA_BBBB_CCCC, 8'h03, 1'b1, 1'b0);
        send(64'hDDDD_EEEE_FFFF_0000, 8'h04, 1'b1, 1'b1);
        drain();
        chk("post_rst_beat_cnt", 64'(beat_cnt), 64'd3);

        // Single-stage instance: literal vectors and 4-bit counter saturation.
        s_vec("s_enc_vec", 64'h0001_0002_0003_0004, 1'b1, 64'h0003_0001_0004_0007);
        s_vec("s_dec_vec", 64'h0003_0001_0004_0007, 1'b0, 64'h0001_0002_0003_0004);
        s_vec("s_rot_wrap", 64'h0000_8000_0000_0000, 1'b1, 64'h0001_0000_0000_0000);
        chk("s_beat_cnt_3", 64'(s_beat_cnt), 64'd3);
        s_in_payload = 1'b1;
        s_in_wr      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        s_in_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("s_beat_cnt_sat", 64'(s_beat_cnt), 64'hF);
        chk("s_idle_busy", 64'(s_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
